wb_arbiter: RTL
===============

# wb_arbiter

Two-master Wishbone (pipelined) arbiter that shares a single slave port, typically the LED walker peripheral, between two bus masters. It grants the slave to one master at a time and holds the grant for the whole bus cycle (`cyc` high). Simultaneous requests are settled by round-robin. An optional watchdog frees the bus from a master that holds `cyc` without making progress.

## Interface
Parameters:
- `AW`, default 1: address width.
- `DW`, default 6: data width.
- `TIMEOUT`, default 16: watchdog limit in cycles. Only used when `WBARB_TIMEOUT_EN` is defined.

Clock and reset:
- `i_clk` in 1: the single clock. All logic is synchronous to its rising edge.
- `i_reset` in 1: synchronous, active-high reset.

Master A:
- `i_a_cyc`, `i_a_stb`, `i_a_we` in 1: bus cycle, strobe, write enable.
- `i_a_addr` in AW: address.
- `i_a_data` in DW: write data.
- `o_a_stall`, `o_a_ack`, `o_a_err` out 1: stall, acknowledge, error.
- `o_a_data` out DW: read data.

Master B:
- `i_b_*` / `o_b_*`: identical to master A.

Slave side:
- `o_cyc`, `o_stb`, `o_we` out 1: bus cycle, strobe, write enable.
- `o_addr` out AW: address.
- `o_data` out DW: write data.
- `i_stall`, `i_ack` in 1: stall and acknowledge from the slave.
- `i_data` in DW: read data from the slave.

## Operation
Registered grant state: IDLE, GNT_A, GNT_B. Also registered: a `last` flag (the most recent owner) and, under the macro, a watchdog counter plus per-master lockout flags.

State transitions:
- **IDLE:**
  - Only A requests (`i_a_cyc`, not locked) → GNT_A.
  - Only B requests → GNT_B.
  - Both request → grant goes to the master that is not `last`.
  - Neither requests → stay in IDLE.
- **GNT_A:**
  - `!i_a_cyc` → GNT_B if `i_b_cyc` (and B not locked), else IDLE. Set `last`=A.
  - Otherwise hold the grant. B's requests are ignored while A owns the bus.
- **GNT_B:** symmetric to GNT_A.

Slave-side muxing (combinational from the grant):
- `o_cyc` = owner's `cyc`; 0 in IDLE.
- `o_stb` = owner's `stb & cyc`; 0 in IDLE.
- `o_we`, `o_addr`, `o_data` = owner's signals; 0 in IDLE.

Master-side returns:
- Owner: `o_x_stall` = `i_stall`, `o_x_ack` = `i_ack`, `o_x_data` = `i_data`.
- Non-owner, or any master in IDLE: `o_x_stall` = 1, `o_x_ack` = 0, `o_x_data` = 0.
- An `i_ack` arriving in IDLE is dropped.
- An ack still outstanding when its owner drops `cyc` is abandoned, per Wishbone rules. It is never delivered to the other master, because the state passes through a switch edge first and `o_cyc` is low for that one cycle.

Reset (`i_reset` high at an edge, including mid-transfer):
- State → IDLE; `last` = B, so A wins the first tie.
- Watchdog counter and lockouts → 0.
- All outputs take their IDLE values from the next cycle: `o_cyc`/`o_stb` = 0, stalls = 1, acks/errs = 0.

## Timing
- **Grant latency:** master raises `cyc`+`stb` in cycle 0. It is stalled in cycle 0, and `o_cyc`/`o_stb` are high in cycle 1.
- **Handover:** owner drops `cyc` in cycle n, with the other master waiting. The new owner drives `o_cyc` in cycle n+1. `o_cyc` is combinationally low in cycle n because it follows the old owner's `cyc`.
- **Pass-through:** stall, ack and data are zero-latency combinational paths. A transfer is accepted on `o_stb & !i_stall`.
- **Back-to-back:** while `cyc` stays high the owner may issue strobes every cycle with no re-arbitration.
- **Tie on the release cycle:** the owner drops `cyc` while the other master requests. The other master wins regardless of `last`.

## Configuration
Macro `WBARB_TIMEOUT_EN`.

Defined:
- The counter resets to 0 on any grant change and on any cycle with `i_ack` or an accepted `o_stb & !i_stall`.
- It increments on every other cycle while the state is GNT_x.
- When it reaches TIMEOUT:
  - `o_x_err` pulses high for one cycle.
  - The state goes to IDLE, or straight to the other master's grant if that master is requesting.
  - The offender's lockout flag is set.
- While locked, the master sees stall = 1 and is ignored by arbitration. The lockout clears on the first cycle its `cyc` is low.

Undefined:
- No counter and no lockout logic.
- `o_a_err` = `o_b_err` = 0 constant.
- A master may hold the bus indefinitely.

## Test plan
- **Single write:** A writes `6'h15` (cyc/stb/we, addr 0) from IDLE, slave acks the next cycle. Expect:
  - `o_a_stall`=1 in cycle 0.
  - Cycle 1: `o_stb`=1, `o_data`=`6'h15`.
  - `o_a_ack`=1 in cycle 2.
  - `o_b_ack`=0 throughout.
- **Tie after reset:** A and B request in the same cycle. Expect A granted first. After A drops `cyc`, B owns with `o_cyc` high one cycle later. A second tie then goes to A (`last`=B).
- **Stalled second requester:** B owns the bus and A requests. Expect `o_a_stall`=1 and `o_a_ack`=0 for the whole of B's cycle, even when slave `i_ack`=1. Grant moves to A on B's release.
- **Slave stall pass-through:** A owns, slave holds `i_stall`=1 for 11 cycles. Expect `o_a_stall` to mirror it exactly, and the watchdog with `WBARB_TIMEOUT_EN` not to fire (TIMEOUT=16).
- **Watchdog (macro defined, TIMEOUT=4):** A holds `cyc` with no stb and no ack. Expect:
  - `o_a_err` pulses in cycle 5 after the grant.
  - `o_cyc` drops, and B's pending request is granted.
  - A is stalled until it drops `cyc`.
- **Reset mid-transfer:** assert `i_reset` while A owns with `stb` high. Expect, the next cycle:
  - `o_cyc`=0, `o_stb`=0, `o_a_stall`=1, `o_a_ack`=0.
  - The first tie after reset is granted to A.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master pipelined Wishbone arbiter sharing one slave port, round-robin on ties.
// Optional watchdog/lockout enabled by defining WBARB_TIMEOUT_EN.
module wb_arbiter #(
    parameter int AW      = 1,
    parameter int DW      = 6,
    parameter int TIMEOUT = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,

    input  logic          i_a_cyc,
    input  logic          i_a_stb,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_data,
    output logic          o_a_stall,
    output logic          o_a_ack,
    output logic          o_a_err,
    output logic [DW-1:0] o_a_data,

    input  logic          i_b_cyc,
    input  logic          i_b_stb,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_data,
    output logic          o_b_stall,
    output logic          o_b_ack,
    output logic          o_b_err,
    output logic [DW-1:0] o_b_data,

    output logic          o_cyc,
    output logic          o_stb,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    input  logic          i_stall,
    input  logic          i_ack,
    input  logic [DW-1:0] i_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t r_state, w_next;
    logic   r_last_b, w_last_b_next;
    logic   w_a_req, w_b_req;
    logic   w_timeout;

`ifdef WBARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_lock_a, r_lock_b;

    assign w_a_req   = i_a_cyc & ~r_lock_a;
    assign w_b_req   = i_b_cyc & ~r_lock_b;
    assign w_timeout = (r_state != IDLE) && (r_cnt == CW'(TIMEOUT));
    assign o_a_err   = (r_state == GNT_A) && w_timeout;
    assign o_b_err   = (r_state == GNT_B) && w_timeout;

    // Any progress (ack or accepted strobe) or a change of owner restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_lock_a <= 1'b0;
            r_lock_b <= 1'b0;
        end else begin
            if ((w_next != r_state) || i_ack || (o_stb && !i_stall))
                r_cnt <= '0;
            else if (r_state != IDLE)
                r_cnt <= r_cnt + 1'b1;

            if ((r_state == GNT_A) && w_timeout)
                r_lock_a <= 1'b1;
            else if (!i_a_cyc)
                r_lock_a <= 1'b0;

            if ((r_state == GNT_B) && w_timeout)
                r_lock_b <= 1'b1;
            else if (!i_b_cyc)
                r_lock_b <= 1'b0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_a_req   = i_a_cyc;
    assign w_b_req   = i_b_cyc;
    assign w_timeout = 1'b0;
    assign o_a_err   = 1'b0;
    assign o_b_err   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_last_b <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_last_b <= w_last_b_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_last_b_next = r_last_b;
        case (r_state)
            IDLE: begin
                if (w_a_req && w_b_req)
                    w_next = r_last_b ? GNT_A : GNT_B;
                else if (w_a_req)
                    w_next = GNT_A;
                else if (w_b_req)
                    w_next = GNT_B;
            end
            GNT_A: begin
                if (!i_a_cyc || w_timeout) begin
                    w_next        = w_b_req ? GNT_B : IDLE;
                    w_last_b_next = 1'b0;
                end
            end
            GNT_B: begin
                if (!i_b_cyc || w_timeout) begin
                    w_next        = w_a_req ? GNT_A : IDLE;
                    w_last_b_next = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_cyc     = 1'b0;
        o_stb     = 1'b0;
        o_we      = 1'b0;
        o_addr    = '0;
        o_data    = '0;
        o_a_stall = 1'b1;
        o_a_ack   = 1'b0;
        o_a_data  = '0;
        o_b_stall = 1'b1;
        o_b_ack   = 1'b0;
        o_b_data  = '0;
        case (r_state)
            GNT_A: begin
                o_cyc     = i_a_cyc;
                o_stb     = i_a_stb & i_a_cyc;
                o_we      = i_a_we;
                o_addr    = i_a_addr;
                o_data    = i_a_data;
                o_a_stall = i_stall;
                o_a_ack   = i_ack;
                o_a_data  = i_data;
            end
            GNT_B: begin
                o_cyc     = i_b_cyc;
                o_stb     = i_b_stb & i_b_cyc;
                o_we      = i_b_we;
                o_addr    = i_b_addr;
                o_data    = i_b_data;
                o_b_stall = i_stall;
                o_b_ack   = i_ack;
                o_b_data  = i_data;
            end
            default: ;
        endcase
    end

endmodule
